outbox_uart_tx: RTL and testbench



---
 rtl/outbox_uart_tx.sv | 144 ++++++++++++++
 tb/tb_outbox_uart_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outbox_uart_tx.sv
// Drains the OUTBOX FIFO onto an 8N1 UART pin; OUTBOX_UART_TX_HEX_EN sends each byte as "HH\n".
// Start bit follows the pop strobe by one cycle; pops only when idle and the FIFO is non-empty.
module outbox_uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_out_empty,
    input  logic [7:0] i_out_data,
    output logic       o_out_rd,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef OUTBOX_UART_TX_HEX_EN
        , HEX1, HEX2, NL
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rd;
    logic          tx;
    logic          wrap;

`ifdef OUTBOX_UART_TX_HEX_EN
    // chr_q tracks which of the three characters of a popped byte is on the wire
    state_t        chr_q, chr_d;
    logic [3:0]    nib_q, nib_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        rd      = 1'b0;
        tx      = 1'b1;
        wrap    = (cnt_q == CNT_MAX);
`ifdef OUTBOX_UART_TX_HEX_EN
        chr_d   = chr_q;
        nib_d   = nib_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!i_out_empty) begin
                    rd      = 1'b1;
                    state_d = START;
                    cnt_d   = '0;
`ifdef OUTBOX_UART_TX_HEX_EN
                    shift_d = hex_ascii(i_out_data[7:4]);
                    nib_d   = i_out_data[3:0];
                    chr_d   = HEX1;
`else
                    shift_d = i_out_data;
`endif
                end
            end
            START: begin
                tx = 1'b0;
                if (wrap) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (wrap) begin
`ifdef OUTBOX_UART_TX_HEX_EN
                    // chained characters skip IDLE so their stop bits stay exactly one bit long
                    case (chr_q)
                        HEX1: begin
                            shift_d = hex_ascii(nib_q);
                            chr_d   = HEX2;
                            state_d = START;
                        end
                        HEX2: begin
                            shift_d = 8'h0A;
                            chr_d   = NL;
                            state_d = START;
                        end
                        default: state_d = IDLE;
                    endcase
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
`ifdef OUTBOX_UART_TX_HEX_EN
            chr_q   <= HEX1;
            nib_q   <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef OUTBOX_UART_TX_HEX_EN
            chr_q   <= chr_d;
            nib_q   <= nib_d;
`endif
        end
    end

    // a pop during a reset cycle would lose the byte, so the strobe is held off
    assign o_out_rd = rd & ~i_rst;
    assign o_tx     = tx;
    assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Bench for outbox_uart_tx: FIFO model on the input side, waveform log of the pin checked
// against ideal 8N1 frames built from the bytes pushed (three characters per byte with OUTBOX_UART_TX_HEX_EN).
module tb_outbox_uart_tx;
    localparam int CPB = 4;
    localparam int FL  = 10 * CPB;
`ifdef OUTBOX_UART_TX_HEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 1;
`endif

    logic       clk;
    logic       i_rst;
    logic       i_out_empty;
    logic [7:0] i_out_data;
    logic       o_out_rd;
    logic       o_tx;
    logic       o_busy;

    outbox_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_out_empty(i_out_empty),
        .i_out_data (i_out_data),
        .o_out_rd   (o_out_rd),
        .o_tx       (o_tx),
        .o_busy     (o_busy)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic       tx_log[$];
    logic       busy_log[$];
    logic       rd_log[$];
    logic [7:0] fifo_q[$];
    logic [7:0] junk_dat = 8'h00;
    int         rd_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample every cycle at the falling edge; protocol rules on the pop strobe checked here.
    initial begin
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            tx_log.push_back(o_tx);
            busy_log.push_back(o_busy);
            rd_log.push_back(o_out_rd);
            if (o_out_rd === 1'b1) begin
                n_assert++;
                if (i_out_empty !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_while_empty: cycle %0d empty=%b required 0", tx_log.size() - 1, i_out_empty);
                end
                n_assert++;
                if (prev_rd) begin
                    n_fail++;
                    $display("FAIL rd_consecutive: cycle %0d rd=1 after rd=1, required a single-cycle pulse", tx_log.size() - 1);
                end
                rd_cnt++;
            end
            prev_rd = o_out_rd;
        end
    end

    // FIFO model: pops after each strobe, presents head byte (or junk when empty).
    initial begin
        int         pop_cnt;
        logic [7:0] tmp;
        pop_cnt     = 0;
        i_out_empty = 1'b1;
        i_out_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            while (pop_cnt < rd_cnt) begin
                if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
                pop_cnt++;
            end
            if (fifo_q.size() > 0) begin
                i_out_empty = 1'b0;
                i_out_data  = fifo_q[0];
            end else begin
                i_out_empty = 1'b1;
                i_out_data  = junk_dat;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // k-th character sent for byte b
    function automatic logic [7:0] ch(input logic [7:0] b, input int k);
`ifdef OUTBOX_UART_TX_HEX_EN
        logic [3:0] n;
        if (k == 2) return 8'h0A;
        n = (k == 0) ? b[7:4] : b[3:0];
        if (n < 4'd10) return 8'd48 + {4'd0, n};
        return 8'd65 + {4'd0, n} - 8'd10;
`else
        return (k == 0) ? b : 8'h00;
`endif
    endfunction

    // number of logged samples deviating from an ideal frame of b starting at cycle s
    function automatic int wave_err(input int s, input logic [7:0] b);
        int         e;
        logic       ex;
        logic [2:0] bi;
        e = 0;
        for (int j = 0; j < FL; j++) begin
            bi = 3'((j - CPB) / CPB);
            if (j < CPB) ex = 1'b0;
            else if (j < 9 * CPB) ex = b[bi];
            else ex = 1'b1;
            if (s + j >= tx_log.size()) e++;
            else if (tx_log[s + j] !== ex) e++;
        end
        return e;
    endfunction

    function automatic logic [7:0] decode(input int s);
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 8; i++)
            if (s + CPB * (i + 1) + CPB / 2 < tx_log.size())
                d[i] = tx_log[s + CPB * (i + 1) + CPB / 2];
        return d;
    endfunction

    function automatic int find_rd(input int from);
        for (int i = from; i < rd_log.size(); i++)
            if (rd_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_rd(input int from);
        int c;
        c = 0;
        for (int i = from; i < rd_log.size(); i++)
            if (rd_log[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        int s, bt, br, bb;
        i_rst = 1'b1;
        run(3);
        i_rst = 1'b0;
        s = tx_log.size();
        run(50);
        bt = 0; br = 0; bb = 0;
        for (int i = s; i < s + 50; i++) begin
            if (tx_log[i] !== 1'b1) bt++;
            if (rd_log[i] !== 1'b0) br++;
            if (busy_log[i] !== 1'b0) bb++;
        end
        n_assert++;
        if (bt != 0) begin n_fail++; $display("FAIL reset_tx: %0d cycles with tx!=1, required 0", bt); end
        n_assert++;
        if (br != 0) begin n_fail++; $display("FAIL reset_rd: %0d cycles with rd!=0, required 0", br); end
        n_assert++;
        if (bb != 0) begin n_fail++; $display("FAIL reset_busy: %0d cycles with busy!=0, required 0", bb); end
    endtask

    task automatic test_single(input logic [7:0] b);
        int s, p, e, nb;
        s = tx_log.size();
        fifo_q.push_back(b);
        run(FL * NCH + 20);
        p = find_rd(s);
        n_assert++;
        if (p < 0) begin
            n_fail++;
            $display("FAIL single_rd_seen: no rd pulse for byte %02h, required one", b);
        end else begin
            n_assert++;
            if (count_rd(s) != 1) begin
                n_fail++;
                $display("FAIL single_rd_count: got %0d pulses, required 1", count_rd(s));
            end
            for (int k = 0; k < NCH; k++) begin
                n_assert++;
                e = wave_err(p + 1 + FL * k, ch(b, k));
                if (e != 0) begin
                    n_fail++;
                    $display("FAIL single_frame%0d: decoded %02h (%0d bad samples), required %02h", k, decode(p + 1 + FL * k), e, ch(b, k));
                end
            end
            nb = 0;
            for (int i = p + 1; i <= p + FL * NCH; i++) if (busy_log[i] === 1'b1) nb++;
            n_assert++;
            if (nb != FL * NCH || busy_log[p] !== 1'b0 || busy_log[p + FL * NCH + 1] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_busy: busy high %0d cycles (before=%b after=%b), required %0d with 0 around", nb, busy_log[p], busy_log[p + FL * NCH + 1], FL * NCH);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s, p[3];
        logic [7:0] v[3];
        v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h80;
        s = tx_log.size();
        for (int i = 0; i < 3; i++) fifo_q.push_back(v[i]);
        run(3 * (FL * NCH + 1) + 20);
        p[0] = find_rd(s);
        p[1] = (p[0] < 0) ? -1 : find_rd(p[0] + 1);
        p[2] = (p[1] < 0) ? -1 : find_rd(p[1] + 1);
        n_assert++;
        if (p[2] < 0 || count_rd(s) != 3) begin
            n_fail++;
            $display("FAIL b2b_rd_count: got %0d pulses, required 3", count_rd(s));
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_assert++;
                if (p[i] - p[i - 1] != FL * NCH + 1) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, p[i] - p[i - 1], FL * NCH + 1);
                end
            end
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < NCH; k++) begin
                    n_assert++;
                    if (wave_err(p[i] + 1 + FL * k, ch(v[i], k)) != 0) begin
                        n_fail++;
                        $display("FAIL b2b_frame%0d_%0d: decoded %02h, required %02h", i, k, decode(p[i] + 1 + FL * k), ch(v[i], k));
                    end
                end
        end
    endtask

    task automatic test_data_stability();
        int p;
        p = -1;
        junk_dat = 8'($urandom);
        fifo_q.push_back(8'h5A);
        for (int t = 0; t < 10 && p < 0; t++) begin
            run(1);
            if (rd_log[rd_log.size() - 1] === 1'b1) p = rd_log.size() - 1;
        end
        n_assert++;
        if (p < 0) begin
            n_fail++;
            $display("FAIL stab_rd_seen: no rd pulse within 10 cycles, required one");
        end else begin
            run(10);
            junk_dat = 8'h3C;
            run(FL * NCH + 10);
            for (int k = 0; k < NCH; k++) begin
                n_assert++;
                if (wave_err(p + 1 + FL * k, ch(8'h5A, k)) != 0) begin
                    n_fail++;
                    $display("FAIL stab_frame%0d: decoded %02h, required %02h", k, decode(p + 1 + FL * k), ch(8'h5A, k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int p, p2;
        logic [7:0] a, b, c;
        a = 8'($urandom);
        b = 8'($urandom);
        p = -1;
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        for (int t = 0; t < 10 && p < 0; t++) begin
            run(1);
            if (rd_log[rd_log.size() - 1] === 1'b1) p = rd_log.size() - 1;
        end
        n_assert++;
        if (p < 0) begin
            n_fail++;
            $display("FAIL rstmid_rd_seen: no rd pulse within 10 cycles, required one");
        end else begin
            run(17);
            i_rst = 1'b1;
            run(1);
            i_rst = 1'b0;
            run(FL * NCH + 20);
            c = ch(a, 0);
            n_assert++;
            if (tx_log[p + 18] !== c[3]) begin
                n_fail++;
                $display("FAIL rstmid_bit3: tx=%b before reset, required %b", tx_log[p + 18], c[3]);
            end
            n_assert++;
            if (tx_log[p + 19] !== 1'b1 || busy_log[p + 19] !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle: tx=%b busy=%b after reset, required 1/0", tx_log[p + 19], busy_log[p + 19]);
            end
            p2 = find_rd(p + 1);
            n_assert++;
            if (count_rd(p + 1) != 1 || p2 != p + 19) begin
                n_fail++;
                $display("FAIL rstmid_rd: %0d pulses after abort (first at +%0d), required 1 at +19", count_rd(p + 1), p2 - p);
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    n_assert++;
                    if (wave_err(p2 + 1 + FL * k, ch(b, k)) != 0) begin
                        n_fail++;
                        $display("FAIL rstmid_next%0d: decoded %02h, required %02h", k, decode(p2 + 1 + FL * k), ch(b, k));
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         s, p, prev, n;
        s = tx_log.size();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'($urandom));
            fifo_q.push_back(exp_q[i]);
            run($urandom_range(0, 60));
        end
        run(8 * (FL * NCH + 1) + 20);
        n = count_rd(s);
        n_assert++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL rand_rd_count: got %0d pulses, required 8", n);
        end
        p = s;
        prev = -1000;
        for (int i = 0; i < 8 && i < n; i++) begin
            p = find_rd(p);
            n_assert++;
            if (p - prev < FL * NCH + 1) begin
                n_fail++;
                $display("FAIL rand_gap%0d: pulses %0d cycles apart, required >= %0d", i, p - prev, FL * NCH + 1);
            end
            for (int k = 0; k < NCH; k++) begin
                n_assert++;
                if (wave_err(p + 1 + FL * k, ch(exp_q[i], k)) != 0) begin
                    n_fail++;
                    $display("FAIL rand_frame%0d_%0d: decoded %02h, required %02h", i, k, decode(p + 1 + FL * k), ch(exp_q[i], k));
                end
            end
            prev = p;
            p = p + 1;
        end
    endtask

    initial begin
        i_rst = 1'b1;
        test_reset();
        test_single(8'hA5);
        test_single(8'h7E);
        test_back_to_back();
        test_data_stability();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
